// File: rtl/freq_pkg.sv
// Shared widths, reference-clock constant and FSM state encoding for the frequency calculator.
package freq_pkg;
  localparam int W  = 32;
  localparam int W2 = 2 * W;
  localparam longint unsigned F_STD_DEF = 64'd50_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/seq_div.sv
// Generic unsigned restoring divider, 2*DW-bit dividend by DW-bit divisor, one quotient bit per cycle.
module seq_div #(
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2*DW-1:0] dividend_i,
  input  logic [DW-1:0]   divisor_i,
  output logic [2*DW-1:0] quotient_o,
  output logic            done_o
);
  localparam int QW = 2 * DW;
  localparam int CW = $clog2(QW);

  // Handshake: start_i is a one-cycle pulse that captures the operands and performs the
  // first step; done_o is a one-cycle pulse exactly QW cycles later, when quotient_o is final.
  logic [DW-1:0] rem_q, div_q;
  logic [QW-1:0] dq_q;
  logic [CW-1:0] cnt_q;
  logic          run_q, done_q;

  logic [DW-1:0] src_rem, src_div, diff_lo, rem_d;
  logic [QW-1:0] src_dq, dq_d;
  logic [DW:0]   trial;
  logic          ge;

  always_comb begin
    src_rem = start_i ? '0 : rem_q;
    src_dq  = start_i ? dividend_i : dq_q;
    src_div = start_i ? divisor_i : div_q;
    trial   = {src_rem, src_dq[QW-1]};
    // Low-bit subtraction is exact whenever trial >= divisor, since the result is < divisor.
    ge      = trial[DW] | (trial[DW-1:0] >= src_div);
    diff_lo = trial[DW-1:0] - src_div;
    rem_d   = ge ? diff_lo : trial[DW-1:0];
    dq_d    = {src_dq[QW-2:0], ge};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      div_q  <= '0;
      dq_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q <= rem_d;
        dq_q  <= dq_d;
        div_q <= divisor_i;
        cnt_q <= CW'(QW - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= rem_d;
        dq_q  <= dq_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient_o = dq_q;
  assign done_o     = done_q;
endmodule

// File: rtl/freq_calc.sv
// Computes F = N * F_STD / M after each gate fall; FREQ_CALC_ROUND_EN selects round-to-nearest.
module freq_calc
  import freq_pkg::*;
#(
  parameter longint unsigned F_STD = F_STD_DEF
) (
  input  logic         clk_50M,
  input  logic         rst,
  input  logic [W-1:0] M,
  input  logic [W-1:0] N,
  input  logic         gate_out,
  output logic [W-1:0] freq,
  output logic         freq_valid,
  output logic         busy,
  output logic         div_zero,
  output logic         sat,
  output logic [1:0]   state_dbg_o
);
  state_e        state_q;
  logic          gate_q;
  logic [W-1:0]  m_l_q, n_l_q, freq_q;
  logic          valid_q, busy_q, dz_q, sat_q;

  logic          trigger, div_start, div_done;
  logic [W2-1:0] dividend, quotient;

  assign trigger   = gate_q & ~gate_out;
  assign div_start = (state_q == LOAD) && (m_l_q != '0);

  always_comb begin
`ifdef FREQ_CALC_ROUND_EN
    dividend = W2'(n_l_q) * W2'(F_STD) + W2'(m_l_q >> 1);
`else
    dividend = W2'(n_l_q) * W2'(F_STD);
`endif
  end

  seq_div #(.DW(W)) u_div (
    .clk_i      (clk_50M),
    .rst_i      (rst),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (m_l_q),
    .quotient_o (quotient),
    .done_o     (div_done)
  );

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= IDLE;
      gate_q  <= 1'b0;
      m_l_q   <= '0;
      n_l_q   <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      gate_q  <= gate_out;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (trigger) begin
          m_l_q   <= M;
          n_l_q   <= N;
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: if (m_l_q == '0) begin
          busy_q  <= 1'b0;
          state_q <= DONE;
        end else begin
          state_q <= DIV;
        end
        DIV: if (div_done) begin
          if (quotient[W2-1:W] != '0) begin
            freq_q <= '1;
            sat_q  <= 1'b1;
          end else begin
            freq_q <= quotient[W-1:0];
            sat_q  <= 1'b0;
          end
          dz_q    <= 1'b0;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        // A zero divisor skips the divider and publishes its result here.
        DONE: begin
          if (m_l_q == '0) begin
            freq_q  <= '0;
            dz_q    <= 1'b1;
            sat_q   <= 1'b0;
            valid_q <= 1'b1;
          end
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign freq        = freq_q;
  assign freq_valid  = valid_q;
  assign busy        = busy_q;
  assign div_zero    = dz_q;
  assign sat         = sat_q;
  assign state_dbg_o = state_q;
endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: arithmetic reference model checked every cycle plus literal expectations.
module tb_freq_calc;
  localparam int W = 32;
  localparam longint unsigned F_STD = 64'd50_000_000;

  logic         clk = 1'b0;
  logic         rst;
  logic         gate_out;
  logic [W-1:0] M, N;
  logic [W-1:0] freq;
  logic         freq_valid, busy, div_zero, sat;
  logic [1:0]   state_dbg;

  freq_calc dut (
    .clk_50M     (clk),
    .rst         (rst),
    .M           (M),
    .N           (N),
    .gate_out    (gate_out),
    .freq        (freq),
    .freq_valid  (freq_valid),
    .busy        (busy),
    .div_zero    (div_zero),
    .sat         (sat),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / cycle index ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit           on = 1'b0;
  bit           pend = 1'b0;
  int           t_trig, v_cyc, b_end;
  logic [W-1:0] r_freq, h_freq;
  bit           r_dz, r_sat, h_dz, h_sat;
  bit           exp_v, exp_b;

  int           obs_n = 0;
  int           obs_cyc;
  logic [W-1:0] obs_freq;
  bit           obs_dz, obs_sat;

  function automatic void model_trigger(input longint unsigned m, input longint unsigned n, input int t);
    longint unsigned num, q;
    if (pend) return;
    pend   = 1'b1;
    t_trig = t;
    if (m == 0) begin
      r_freq = '0; r_dz = 1'b1; r_sat = 1'b0;
      b_end  = t + 1;
      v_cyc  = t + 3;
    end else begin
      num = n * F_STD;
`ifdef FREQ_CALC_ROUND_EN
      num = num + m / 2;
`endif
      q = num / m;
      r_dz = 1'b0;
      if (q > 64'hFFFF_FFFF) begin
        r_freq = '1; r_sat = 1'b1;
      end else begin
        r_freq = W'(q); r_sat = 1'b0;
      end
      b_end = t + 2 * W + 1;
      v_cyc = t + 2 * W + 2;
    end
  endfunction

  function automatic void model_reset();
    pend = 1'b0;
    h_freq = '0; h_dz = 1'b0; h_sat = 1'b0;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (on) begin
      exp_v = pend && (cyc == v_cyc);
      if (exp_v) begin
        h_freq = r_freq; h_dz = r_dz; h_sat = r_sat;
        pend = 1'b0;
      end
      exp_b = pend && (cyc > t_trig) && (cyc <= b_end);
      chk("freq_valid", freq_valid, exp_v);
      chk("busy", busy, exp_b);
      chk("freq", freq, h_freq);
      chk("div_zero", div_zero, h_dz);
      chk("sat", sat, h_sat);
      if (freq_valid) begin
        obs_n++;
        obs_cyc = cyc; obs_freq = freq; obs_dz = div_zero; obs_sat = sat;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic gate_fall(input logic [W-1:0] m, input logic [W-1:0] n);
    tick(); gate_out = 1'b1;
    tick(); gate_out = 1'b0; M = m; N = n;
    model_trigger(m, n, cyc);
  endtask

  task automatic wait_valid(input int prev, input string name);
    int k = 0;
    while (obs_n == prev && k < 200) begin
      tick(); k++;
    end
    if (obs_n == prev) chk({name, "_timeout"}, obs_n, prev + 1);
  endtask

  task automatic run_meas(input logic [W-1:0] m, input logic [W-1:0] n, input string name,
                          input logic [W-1:0] e_freq, input bit e_dz, input bit e_sat, input int e_lat);
    int prev, t;
    prev = obs_n;
    gate_fall(m, n);
    t = cyc;
    wait_valid(prev, name);
    chk({name, "_freq"}, obs_freq, e_freq);
    chk({name, "_div_zero"}, obs_dz, e_dz);
    chk({name, "_sat"}, obs_sat, e_sat);
    chk({name, "_latency"}, obs_cyc - t, e_lat);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, t;
    rst = 1'b1; gate_out = 1'b0; M = '0; N = '0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    on = 1'b1;
    tick();

    run_meas(32'd50_000_000, 32'd1_000, "t1_1khz", 32'd1000, 1'b0, 1'b0, 66);
`ifdef FREQ_CALC_ROUND_EN
    run_meas(32'd50_000_001, 32'd3, "t2_round", 32'd3, 1'b0, 1'b0, 66);
    run_meas(32'd3, 32'd1, "third", 32'd16_666_667, 1'b0, 1'b0, 66);
`else
    run_meas(32'd50_000_001, 32'd3, "t2_trunc", 32'd2, 1'b0, 1'b0, 66);
    run_meas(32'd3, 32'd1, "third", 32'd16_666_666, 1'b0, 1'b0, 66);
`endif
    run_meas(32'd0, 32'd7, "t3_m_zero", 32'd0, 1'b1, 1'b0, 3);
    run_meas(32'd1, 32'd100, "t4_sat", 32'hFFFF_FFFF, 1'b0, 1'b1, 66);
    run_meas(32'd1, 32'd85, "sat_edge_lo", 32'd4_250_000_000, 1'b0, 1'b0, 66);
    run_meas(32'd1, 32'd86, "sat_edge_hi", 32'hFFFF_FFFF, 1'b0, 1'b1, 66);
    run_meas(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_mn", 32'd50_000_000, 1'b0, 1'b0, 66);
    run_meas(32'd0, 32'd0, "restart_zero", 32'd0, 1'b1, 1'b0, 3);

    // Second gate fall while busy must be ignored.
    prev = obs_n;
    gate_fall(32'd50_000_000, 32'd5_000);
    t = cyc;
    while (cyc < t + 8) tick();
    gate_fall(32'd25_000_000, 32'd5);
    wait_valid(prev, "t5");
    chk("t5_freq", obs_freq, 32'd5000);
    chk("t5_latency", obs_cyc - t, 66);
    prev = obs_n;
    repeat (80) tick();
    chk("t5_no_extra_result", obs_n, prev);

    // Reset in the middle of a division discards it.
    prev = obs_n;
    gate_fall(32'd50_000_000, 32'd1_000);
    t = cyc;
    while (cyc < t + 30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t6_busy_after_rst", busy, 1'b0);
    chk("t6_freq_after_rst", freq, 32'd0);
    tick();
    repeat (80) tick();
    chk("t6_no_result", obs_n, prev);
`ifdef FREQ_CALC_ROUND_EN
    run_meas(32'd20_000_000, 32'd7, "t6_after_rst", 32'd18, 1'b0, 1'b0, 66);
`else
    run_meas(32'd20_000_000, 32'd7, "t6_after_rst", 32'd17, 1'b0, 1'b0, 66);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
